// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, divide-by-zero flagged on overflow.
// Optional DIVIDER_STICKY_DONE_EN: done/overflow held in DONE until next accepted start (default: done pulses).
module divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_a,
    input  logic [WIDTH-1:0] dividen,
    input  logic [WIDTH-1:0] divisor,
    input  logic             start,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef DIVIDER_STICKY_DONE_EN
    localparam state_t FINISH_STATE = DONE;
`else
    localparam state_t FINISH_STATE = IDLE;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    // Shifted partial remainder carries one extra bit so the compare never loses the MSB.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             q_bit;
    logic             accept;

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        remd_d    = remd_q;
        done_d    = done_q;
        ovf_d     = ovf_q;

        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, dsr_q});
        rem_sub   = rem_shift[WIDTH-1:0] - dsr_q;
        accept    = start && (state_q != RUN);

        if (accept) begin
            dvd_d   = dividen;
            dsr_d   = divisor;
            rem_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (dsr_q == '0) begin
                quot_d  = '1;
                remd_d  = dvd_q;
                ovf_d   = 1'b1;
                done_d  = 1'b1;
                state_d = FINISH_STATE;
            end else begin
                // Quotient bits shift into the dividend register as its bits shift out.
                rem_d = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    quot_d  = dvd_d;
                    remd_d  = rem_d;
                    done_d  = 1'b1;
                    state_d = FINISH_STATE;
                end
            end
        end else if (state_q == IDLE) begin
`ifndef DIVIDER_STICKY_DONE_EN
            done_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = remd_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: expected results are queued at issue and popped when done rises.
module tb_divider;

    localparam int W = 16;
`ifdef DIVIDER_STICKY_DONE_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_a;
    logic         start;
    logic [W-1:0] dividen;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        logic [7:0]   lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .dividen   (dividen),
        .divisor   (divisor),
        .start     (start),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        dividen = a;
        divisor = b;
        start   = 1'b1;
        e.q   = (b == '0) ? {W{1'b1}} : a / b;
        e.r   = (b == '0) ? a : a % b;
        e.ovf = (b == '0);
        e.lat = (b == '0) ? 8'd1 : 8'd16;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        $display("issue %0d / %0d -> expect q=%0d r=%0d ovf=%0b", a, b, e.q, e.r, e.ovf);
        check("accept_done", {31'd0, done}, 32'd0);
        check("accept_ovf", {31'd0, overflow}, 32'd0);
    endtask

    task automatic collect(input int poke_at);
        exp_t         e;
        int           n;
        logic [W-1:0] held_q;
        logic         held_ok;
        held_q  = quotient;
        held_ok = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (quotient !== held_q) held_ok = 1'b0;
            if (n == poke_at) begin
                dividen = 16'd9;
                divisor = 16'd4;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        $display("result after %0d cycles: q=%0d r=%0d ovf=%0b done=%0b", n, quotient, remainder, overflow, done);
        check("latency", n, {24'd0, e.lat});
        check("done", {31'd0, done}, 32'd1);
        check("quotient", {16'd0, quotient}, {16'd0, e.q});
        check("remainder", {16'd0, remainder}, {16'd0, e.r});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("hold_in_run", {31'd0, held_ok}, 32'd1);
    endtask

    task automatic after_done(input logic [W-1:0] exp_q, input logic exp_ovf);
        @(posedge clk);
        #1;
        check("done_after", {31'd0, done}, {31'd0, STICKY});
        check("q_hold", {16'd0, quotient}, {16'd0, exp_q});
        check("ovf_hold", {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    initial begin
        reset_a = 1'b0;
        start   = 1'b0;
        dividen = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", {16'd0, quotient}, 32'd0);
        check("rst_r", {16'd0, remainder}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset_a = 1'b1;

        issue(16'd5, 16'd2);      collect(0); after_done(16'd2, 1'b0);
        issue(16'd8, 16'd2);      collect(0);
        issue(16'd100, 16'd7);    collect(0); after_done(16'd14, 1'b0);
        issue(16'hFFFF, 16'd1);   collect(0);
        issue(16'd3, 16'hFFFF);   collect(0);
        issue(16'd1234, 16'd0);   collect(0); after_done(16'hFFFF, 1'b1);
        issue(16'd8, 16'd2);      collect(0);

        // Second start mid-run must be ignored; latency stays 16.
        issue(16'd5, 16'd2);      collect(5);

        // Asynchronous reset mid-run.
        issue(16'd5, 16'd2);
        repeat (7) @(posedge clk);
        #2;
        reset_a = 1'b0;
        #1;
        sb.delete();
        $display("reset asserted mid-run: q=%0d r=%0d done=%0b ovf=%0b", quotient, remainder, done, overflow);
        check("mid_rst_q", {16'd0, quotient}, 32'd0);
        check("mid_rst_r", {16'd0, remainder}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_a = 1'b1;
        issue(16'd9, 16'd4);      collect(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider.md
# divider

Sequential 16-bit unsigned integer divider for the ALU datapath. It takes a dividend and divisor on a single-cycle `start` request and computes quotient and remainder by restoring shift-subtract, one quotient bit per clock. It reports completion on `done` and flags division by zero on `overflow`. Results hold until the next accepted request.

## Interface
- `WIDTH`, default 16: operand and result width; all data ports are `WIDTH` bits.
- `clk`  input  1  rising-edge clock.
- `reset_a`  input  1  asynchronous, active-low reset.
- `dividen`  input  WIDTH  dividend, unsigned; sampled when `start` is accepted.
- `divisor`  input  WIDTH  divisor, unsigned; sampled when `start` is accepted.
- `start`  input  1  request; accepted on a rising edge in IDLE or DONE.
- `quotient`  output  WIDTH  registered quotient.
- `remainder`  output  WIDTH  registered remainder.
- `done`  output  1  result valid.
- `overflow`  output  1  last accepted request had divisor == 0.

## Operation
- States:
  - IDLE: after reset; waiting for `start`.
  - RUN: iterating.
  - DONE: result presented.
- Accept:
  - Applies when `start`=1 at an edge in IDLE or DONE.
  - Latch `dividen` and `divisor`.
  - Clear partial remainder and iteration counter.
  - Clear `done` and `overflow`.
  - Go to RUN.
- `start` in RUN is ignored. Operands are not re-sampled.
- RUN iteration (restoring algorithm), per edge:
  - Shift {partial remainder, dividend} left 1.
  - If the partial remainder is >= divisor, subtract the divisor and shift in quotient bit 1; else shift in 0.
  - Partial remainder is WIDTH+1 bits to avoid loss on shift.
- After WIDTH iterations:
  - Load `quotient` and `remainder` registers.
  - Set `done`.
  - Go to DONE.
- Divide by zero, detected on the first RUN edge:
  - Skip the iterations.
  - `quotient` = all ones (16'hFFFF).
  - `remainder` = latched dividend.
  - `overflow` = 1, `done` = 1.
  - Go to DONE.
- `quotient` and `remainder` change only on completion. They hold their previous values during RUN.
- Reset (`reset_a`=0, any time, including mid-RUN):
  - Immediately force IDLE.
  - `quotient`=0, `remainder`=0, `done`=0, `overflow`=0.
  - Clear the counter and internal registers.
- Release of reset is synchronous to the next `clk` edge.

## Timing
- Edge E0: `start` accepted.
- Normal latency:
  - Edges E1..E16 perform the 16 iterations.
  - Results and `done`=1 are visible after E16.
  - 16 cycles from acceptance.
- Divide-by-zero latency: `done`=1 and `overflow`=1 visible after E1.
- Back-to-back operation:
  - `start` at the edge where DONE is already held is accepted.
  - `done` drops after that edge.
  - Minimum issue interval is 17 cycles.
- `start` held high across several cycles in RUN has no effect.
- `start` still high when DONE is reached restarts the divider on the next edge.

## Configuration
- Macro `DIVIDER_STICKY_DONE_EN`.
- Defined:
  - `done` stays high in DONE until the next accepted `start` or reset.
  - `overflow` follows the same rule.
- Undefined:
  - `done` is a one-cycle pulse on the edge after completion; the FSM returns directly to IDLE.
  - `overflow`, `quotient` and `remainder` still hold until the next accepted `start` or reset.

## Test plan
- Reset low, then high; `dividen`=5, `divisor`=2; one-cycle `start` -> after 16 cycles `quotient`=2, `remainder`=1, `done`=1, `overflow`=0.
- `dividen`=8, `divisor`=2 -> `quotient`=4, `remainder`=0. Then `dividen`=100, `divisor`=7 back-to-back -> `quotient`=14, `remainder`=2.
- `dividen`=16'hFFFF, `divisor`=1 -> `quotient`=16'hFFFF, `remainder`=0. `dividen`=3, `divisor`=16'hFFFF -> `quotient`=0, `remainder`=3.
- `dividen`=1234, `divisor`=0 -> after 1 cycle `done`=1, `overflow`=1, `quotient`=16'hFFFF, `remainder`=1234. Next valid request clears `overflow`.
- Start 5/2, pulse `start` again at cycle 5 with 9/4 -> second start ignored; result 2 r1 at cycle 16.
- Start 5/2, assert `reset_a`=0 at cycle 8 -> all outputs 0 immediately, no `done`. After release, start 9/4 -> `quotient`=2, `remainder`=1.
